// File: rtl/ra_bist_march_ctl.sv
// ra_bist_march_ctl
//   March C- BIST sequencer for the 64x72 toysram register array
//   (2 read ports, 1 write port). While busy=1 the array-side mux selects
//   the bist_* stimulus produced here. Read data from both ports is checked
//   against the expected background, and pass/fail plus first-fail debug
//   information is reported.
//
//   Elements (B = background, ~B = inverse background):
//     E0 up w(B)   E1 up r(B),w(~B)   E2 up r(~B),w(B)
//     E3 dn r(B),w(~B)   E4 dn r(~B),w(B)   E5 up r(B)
//
// Configuration macro:
//   BIST_CHECKERBOARD_EN - after the solid pass, repeat E0..E5 with a
//                          checkerboard background and add the fail_bg port.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, abort          run control (abort wins over start)
//   busy, done, pass      run status
//   fail, fail_elem,
//   fail_adr, fail_port,
//   err_cnt               sticky miscompare flag and first-fail capture
//   fail_bg               background of first miscompare (checkerboard build only)
//   bist_rd0/rd1_*        read stimulus (both ports share enable/address)
//   bist_wr0_*            write stimulus
//   rd0_dat, rd1_dat      array read data, valid RD_LAT cycles after enable
//   dbg_state             current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Control handshake: start is a single-cycle request sampled on the rising
// edge; it is accepted only in IDLE or DONE and only when abort is low.
// abort is sampled every edge and returns the FSM to IDLE from any state.
module ra_bist_march_ctl #(
    parameter int ADR_W  = 6,
    parameter int DAT_W  = 72,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [2:0]       fail_elem,
    output logic [ADR_W-1:0] fail_adr,
    output logic [1:0]       fail_port,
    output logic [7:0]       err_cnt,
`ifdef BIST_CHECKERBOARD_EN
    output logic             fail_bg,
`endif
    output logic             bist_rd0_enb,
    output logic [ADR_W-1:0] bist_rd0_adr,
    output logic             bist_rd1_enb,
    output logic [ADR_W-1:0] bist_rd1_adr,
    output logic             bist_wr0_enb,
    output logic [ADR_W-1:0] bist_wr0_adr,
    output logic [DAT_W-1:0] bist_wr0_dat,
    input  logic [DAT_W-1:0] rd0_dat,
    input  logic [DAT_W-1:0] rd1_dat,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

`ifdef BIST_CHECKERBOARD_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    localparam logic [ADR_W-1:0] IDX_MAX    = '1;
    localparam logic [1:0]       DRAIN_LAST = 2'(RD_LAT - 1);
    localparam logic [DAT_W-1:0] PAT_SOLID  = '0;
    localparam logic [DAT_W-1:0] PAT_CHECK  = {(DAT_W/2){2'b01}};

    state_t           state_q, state_d;
    logic             launch;
    logic [2:0]       elem_q;
    logic [ADR_W-1:0] idx_q;
    logic             phase_q;   // 0: read slot, 1: write slot of an r,w element
    logic             bg_q;      // 0: solid background, 1: checkerboard
    logic [1:0]       drain_q;

    logic             run;
    logic             rw_elem;
    logic             down_elem;
    logic             op_rd;
    logic             op_wr;
    logic             last_op;
    logic [ADR_W-1:0] op_adr;
    logic [DAT_W-1:0] bg_pat;
    logic [DAT_W-1:0] exp_dat;
    logic [DAT_W-1:0] wr_dat;

    // Compare pipe: one entry per read, aligned with the array read latency.
    logic             pv_q    [RD_LAT];
    logic [2:0]       pelem_q [RD_LAT];
    logic [ADR_W-1:0] padr_q  [RD_LAT];
    logic [DAT_W-1:0] pexp_q  [RD_LAT];
`ifdef BIST_CHECKERBOARD_EN
    logic             pbg_q   [RD_LAT];
`endif

    logic             mis0;
    logic             mis1;
    logic             cmp_hit;

    // ------------------------------------------------------------------
    // Sequencing decode
    // ------------------------------------------------------------------
    always_comb begin
        run       = (state_q == S_RUN);
        rw_elem   = (elem_q >= 3'd1) && (elem_q <= 3'd4);
        down_elem = (elem_q == 3'd3) || (elem_q == 3'd4);
        // E0 is write-only, E5 read-only; r,w elements read in phase 0.
        op_rd     = run && (elem_q != 3'd0) && !phase_q;
        op_wr     = run && ((elem_q == 3'd0) || phase_q);
        op_adr    = down_elem ? ~idx_q : idx_q;
        bg_pat    = bg_q ? PAT_CHECK : PAT_SOLID;
        // Odd elements read B and write ~B; even elements the opposite.
        exp_dat   = elem_q[0] ? bg_pat : ~bg_pat;
        wr_dat    = elem_q[0] ? ~bg_pat : bg_pat;
        last_op   = run && (elem_q == 3'd5) && (idx_q == IDX_MAX) &&
                    (bg_q || !CHK_EN);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                    launch  = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_op) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Element / address / phase counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem_q  <= 3'd0;
            idx_q   <= '0;
            phase_q <= 1'b0;
            bg_q    <= 1'b0;
            drain_q <= 2'd0;
        end else begin
            if (launch) begin
                elem_q  <= 3'd0;
                idx_q   <= '0;
                phase_q <= 1'b0;
                bg_q    <= 1'b0;
            end else if (run) begin
                if (rw_elem && !phase_q) begin
                    phase_q <= 1'b1;
                end else begin
                    phase_q <= 1'b0;
                    idx_q   <= idx_q + 1'b1;   // wraps to 0 at element end
                    if (idx_q == IDX_MAX) begin
                        if (elem_q == 3'd5) begin
                            elem_q <= 3'd0;
                            bg_q   <= CHK_EN;
                        end else begin
                            elem_q <= elem_q + 3'd1;
                        end
                    end
                end
            end
            drain_q <= (state_q == S_DRAIN) ? drain_q + 2'd1 : 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Compare pipe (flushed on abort so pending compares are dropped)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i]    <= 1'b0;
                pelem_q[i] <= 3'd0;
                padr_q[i]  <= '0;
                pexp_q[i]  <= '0;
`ifdef BIST_CHECKERBOARD_EN
                pbg_q[i]   <= 1'b0;
`endif
            end
        end else begin
            pv_q[0]    <= op_rd && !abort;
            pelem_q[0] <= elem_q;
            padr_q[0]  <= op_adr;
            pexp_q[0]  <= exp_dat;
`ifdef BIST_CHECKERBOARD_EN
            pbg_q[0]   <= bg_q;
`endif
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i]    <= pv_q[i-1] && !abort;
                pelem_q[i] <= pelem_q[i-1];
                padr_q[i]  <= padr_q[i-1];
                pexp_q[i]  <= pexp_q[i-1];
`ifdef BIST_CHECKERBOARD_EN
                pbg_q[i]   <= pbg_q[i-1];
`endif
            end
        end
    end

    always_comb begin
        mis0    = (rd0_dat != pexp_q[RD_LAT-1]);
        mis1    = (rd1_dat != pexp_q[RD_LAT-1]);
        cmp_hit = pv_q[RD_LAT-1] && !abort && (mis0 || mis1);
    end

    // ------------------------------------------------------------------
    // Result capture: fail is sticky, first-fail fields load only once
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail      <= 1'b0;
            fail_elem <= 3'd0;
            fail_adr  <= '0;
            fail_port <= 2'b00;
            err_cnt   <= 8'd0;
`ifdef BIST_CHECKERBOARD_EN
            fail_bg   <= 1'b0;
`endif
        end else if (launch) begin
            fail      <= 1'b0;
            fail_elem <= 3'd0;
            fail_adr  <= '0;
            fail_port <= 2'b00;
            err_cnt   <= 8'd0;
`ifdef BIST_CHECKERBOARD_EN
            fail_bg   <= 1'b0;
`endif
        end else if (cmp_hit) begin
            fail <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (!fail) begin
                fail_elem <= pelem_q[RD_LAT-1];
                fail_adr  <= padr_q[RD_LAT-1];
                fail_port <= {mis1, mis0};
`ifdef BIST_CHECKERBOARD_EN
                fail_bg   <= pbg_q[RD_LAT-1];
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (addresses/data forced to 0 when the port is idle)
    // ------------------------------------------------------------------
    always_comb begin
        busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
        done         = (state_q == S_DONE);
        pass         = done && !fail;
        bist_rd0_enb = op_rd;
        bist_rd1_enb = op_rd;
        bist_rd0_adr = op_rd ? op_adr : '0;
        bist_rd1_adr = op_rd ? op_adr : '0;
        bist_wr0_enb = op_wr;
        bist_wr0_adr = op_wr ? op_adr : '0;
        bist_wr0_dat = op_wr ? wr_dat : '0;
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_ra_bist_march_ctl.sv
// tb_ra_bist_march_ctl
//   Directed bench for ra_bist_march_ctl with a behavioural 64x72 array
//   model (1-cycle registered read) that can inject a stuck-at bit at 0x2A
//   and a write-coupling fault 0x10 -> 0x11.
module tb_ra_bist_march_ctl;

  localparam int ADR_W  = 6;
  localparam int DAT_W  = 72;
  localparam int RD_LAT = 1;
  localparam int LOG_N  = 2048;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [2:0]       fail_elem;
  logic [ADR_W-1:0] fail_adr;
  logic [1:0]       fail_port;
  logic [7:0]       err_cnt;
  logic             bist_rd0_enb;
  logic [ADR_W-1:0] bist_rd0_adr;
  logic             bist_rd1_enb;
  logic [ADR_W-1:0] bist_rd1_adr;
  logic             bist_wr0_enb;
  logic [ADR_W-1:0] bist_wr0_adr;
  logic [DAT_W-1:0] bist_wr0_dat;
  logic [DAT_W-1:0] rd0_dat;
  logic [DAT_W-1:0] rd1_dat;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  ra_bist_march_ctl #(.ADR_W(ADR_W), .DAT_W(DAT_W), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .fail_elem    (fail_elem),
    .fail_adr     (fail_adr),
    .fail_port    (fail_port),
    .err_cnt      (err_cnt),
    .bist_rd0_enb (bist_rd0_enb),
    .bist_rd0_adr (bist_rd0_adr),
    .bist_rd1_enb (bist_rd1_enb),
    .bist_rd1_adr (bist_rd1_adr),
    .bist_wr0_enb (bist_wr0_enb),
    .bist_wr0_adr (bist_wr0_adr),
    .bist_wr0_dat (bist_wr0_dat),
    .rd0_dat      (rd0_dat),
    .rd1_dat      (rd1_dat),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- array model ----------------
  logic [DAT_W-1:0] mem [0:63];
  bit stuck_en  = 1'b0;
  bit couple_en = 1'b0;

  function automatic logic [DAT_W-1:0] rd_model(input logic [ADR_W-1:0] a);
    logic [DAT_W-1:0] d;
    d = mem[a];
    if (stuck_en && a == 6'h2A) d[5] = 1'b1;
    return d;
  endfunction

  always @(posedge clk) begin
    if (bist_wr0_enb) mem[bist_wr0_adr] <= bist_wr0_dat;
    if (couple_en && bist_wr0_enb && bist_wr0_adr == 6'h10) mem[6'h11] <= '1;
    rd0_dat <= rd_model(bist_rd0_adr);
    rd1_dat <= rd_model(bist_rd1_adr);
  end

  // ---------------- operation monitor ----------------
  int cur_busy = 0, cur_rd = 0, cur_wr = 0, cur_bad = 0;
  int last_busy = 0, last_rd = 0, last_wr = 0, last_bad = 0;
  int idle_bad = 0;
  bit was_busy = 1'b0;
  logic             log_rd  [0:LOG_N-1];
  logic             log_wr  [0:LOG_N-1];
  logic [ADR_W-1:0] log_adr [0:LOG_N-1];
  logic [DAT_W-1:0] log_dat [0:LOG_N-1];

  always @(negedge clk) begin
    if (busy) begin
      if (cur_busy < LOG_N) begin
        log_rd[cur_busy]  = bist_rd0_enb;
        log_wr[cur_busy]  = bist_wr0_enb;
        log_adr[cur_busy] = bist_rd0_enb ? bist_rd0_adr : bist_wr0_adr;
        log_dat[cur_busy] = bist_wr0_dat;
      end
      cur_busy++;
      if (bist_rd0_enb) cur_rd++;
      if (bist_wr0_enb) cur_wr++;
      if ((bist_rd0_enb && bist_wr0_enb) || (bist_rd0_enb != bist_rd1_enb) ||
          (bist_rd0_adr != bist_rd1_adr)) cur_bad++;
    end else begin
      if (bist_rd0_enb || bist_rd1_enb || bist_wr0_enb) idle_bad++;
      if (was_busy) begin
        last_busy = cur_busy; last_rd = cur_rd; last_wr = cur_wr; last_bad = cur_bad;
        cur_busy = 0; cur_rd = 0; cur_wr = 0; cur_bad = 0;
      end
    end
    was_busy = busy;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [DAT_W-1:0] obs,
                       input logic [DAT_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_op(input string tag, input int c, input logic rd,
                          input logic wr, input logic [ADR_W-1:0] adr,
                          input logic [DAT_W-1:0] dat);
    check({tag, "_rd"}, DAT_W'(log_rd[c]), DAT_W'(rd));
    check({tag, "_wr"}, DAT_W'(log_wr[c]), DAT_W'(wr));
    check({tag, "_adr"}, DAT_W'(log_adr[c]), DAT_W'(adr));
    if (wr) check({tag, "_dat"}, log_dat[c], dat);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, DAT_W'({busy, done, pass, bist_rd0_enb, bist_rd1_enb,
                                 bist_wr0_enb, dbg_state}), '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, DAT_W'({busy, done, pass, fail, fail_elem, fail_port,
                                  fail_adr, err_cnt, bist_rd0_enb, bist_rd0_adr,
                                  bist_rd1_enb, bist_rd1_adr, bist_wr0_enb,
                                  bist_wr0_adr, dbg_state}), '0);
    check({tag, "_wdat"}, bist_wr0_dat, '0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    check({tag, "_done_seen"}, DAT_W'(done), DAT_W'(1'b1));
    @(negedge clk);  // lets the monitor publish its run totals
  endtask

  task automatic check_clean_run(input string tag);
    check({tag, "_busy_cyc"}, DAT_W'(last_busy), DAT_W'(641));
    check({tag, "_pass"}, DAT_W'({done, pass, fail}), DAT_W'(3'b110));
    check({tag, "_err_cnt"}, DAT_W'(err_cnt), '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1: fault-free run, timing and stimulus sequence
    pulse_start();
    wait_done("t1");
    check_clean_run("t1");
    check("t1_state", DAT_W'(dbg_state), DAT_W'(2'd3));
    check("t1_rd_cnt", DAT_W'(last_rd), DAT_W'(320));
    check("t1_wr_cnt", DAT_W'(last_wr), DAT_W'(320));
    check("t1_rules", DAT_W'(last_bad), '0);
    check_op("t1_c0",   0,   1'b0, 1'b1, 6'd0,  '0);
    check_op("t1_c63",  63,  1'b0, 1'b1, 6'd63, '0);
    check_op("t1_c64",  64,  1'b1, 1'b0, 6'd0,  '0);
    check_op("t1_c65",  65,  1'b0, 1'b1, 6'd0,  '1);
    check_op("t1_c193", 193, 1'b0, 1'b1, 6'd0,  '0);
    check_op("t1_c320", 320, 1'b1, 1'b0, 6'd63, '0);
    check_op("t1_c321", 321, 1'b0, 1'b1, 6'd63, '1);
    check_op("t1_c447", 447, 1'b0, 1'b1, 6'd0,  '1);
    check_op("t1_c449", 449, 1'b0, 1'b1, 6'd63, '0);
    check_op("t1_c576", 576, 1'b1, 1'b0, 6'd0,  '0);
    check_op("t1_c639", 639, 1'b1, 1'b0, 6'd63, '0);
    check("t1_c640_idle", DAT_W'({log_rd[640], log_wr[640]}), '0);

    // 2: bit 5 stuck-at-1 at 0x2A
    stuck_en = 1'b1;
    pulse_start();
    wait_done("t2");
    check("t2_pass", DAT_W'({done, pass, fail}), DAT_W'(3'b101));
    check("t2_elem", DAT_W'(fail_elem), DAT_W'(3'd1));
    check("t2_adr", DAT_W'(fail_adr), DAT_W'(6'h2A));
    check("t2_port", DAT_W'(fail_port), DAT_W'(2'b11));
    check("t2_err_cnt", DAT_W'(err_cnt), DAT_W'(8'd3));
    stuck_en = 1'b0;

    // 3: coupling fault, write 0x10 sets 0x11
    couple_en = 1'b1;
    pulse_start();
    wait_done("t3");
    check("t3_fail", DAT_W'({pass, fail}), DAT_W'(2'b01));
    check("t3_elem", DAT_W'(fail_elem), DAT_W'(3'd1));
    check("t3_adr", DAT_W'(fail_adr), DAT_W'(6'h11));
    check("t3_port", DAT_W'(fail_port), DAT_W'(2'b11));
    couple_en = 1'b0;

    // 4: abort at cycle 200, debug fields retained, then clean rerun
    stuck_en = 1'b1;
    pulse_start();
    repeat (199) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_quiet("t4_abort");
    check("t4_keep_fail", DAT_W'(fail), DAT_W'(1'b1));
    check("t4_keep_adr", DAT_W'(fail_adr), DAT_W'(6'h2A));
    check("t4_keep_cnt", DAT_W'(err_cnt), DAT_W'(8'd1));
    stuck_en = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_done("t4b");
    check_clean_run("t4b");

    // 5: start while busy ignored; start+abort together go to IDLE
    pulse_start();
    repeat (299) @(negedge clk);
    pulse_start();
    wait_done("t5");
    check_clean_run("t5");
    check("t5_rd_cnt", DAT_W'(last_rd), DAT_W'(320));
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_quiet("t5_both_done");
    pulse_start();
    repeat (50) @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_quiet("t5_both_run");

    // 6: asynchronous reset mid-run
    stuck_en = 1'b1;
    @(negedge clk);
    pulse_start();
    repeat (200) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("t6_async");
    @(negedge clk);
    reset = 1'b0;
    stuck_en = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_done("t6");
    check_clean_run("t6");

    check("idle_enables", DAT_W'(idle_bad), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
